// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the inter-stage pipeline register.
// The stage payload bundles the 4x32 datapath words with the decoded control
// word, so every stage latch can be sized as DATA_W = $bits(stage_payload_t).
package pipe_stage_skid_pkg;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] imm_sel;
    logic [1:0] wb_sel;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       branch;
    logic       jump;
    logic [1:0] csr_op;
  } bundle_decode_t;

  typedef struct packed {
    logic [31:0]    addr;
    logic [31:0]    target;
    logic [31:0]    pc4;
    logic [31:0]    wd;
    bundle_decode_t ctrl;
  } stage_payload_t;

  localparam int STAGE_DATA_W = $bits(stage_payload_t);

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake, flush and an
// optional skid entry. out_data is always the main entry; the skid entry only
// exists to absorb one stalled beat so in_ready can be driven from a flop.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int          DATA_W         = STAGE_DATA_W,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              acc_in;
  logic              main_free;

  // Flush discards the same-cycle input even if in_ready is high.
  assign acc_in    = in_valid & in_ready & ~flush;
  // Main can take a new value when it is empty or its current value leaves.
  assign main_free = ~main_valid | out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid_q;
      logic [DATA_W-1:0] skid_data_q;

      // Park an accepted beat while main is stalled; it moves to main on the next transfer out.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          skid_valid_q <= 1'b0;
          skid_data_q  <= '0;
        end else if (flush) begin
          skid_valid_q <= 1'b0;
          if (CLEAR_ON_FLUSH != 0) skid_data_q <= '0;
        end else if (skid_valid_q) begin
          if (out_ready) skid_valid_q <= 1'b0;
        end else if (acc_in && !main_free) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= in_data;
        end
      end

      assign skid_valid = skid_valid_q;
      assign skid_data  = skid_data_q;
      assign in_ready   = ~skid_valid_q;
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign in_ready   = main_free;
    end
  endgenerate

  // Main entry: refill from skid first to keep FIFO order, else from the input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      if (CLEAR_ON_FLUSH != 0) main_data <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
      end else if (acc_in) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: one SKID=1 and one SKID=0 stage share the same stimulus;
// each has its own FIFO reference model of accepted payloads.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int W = STAGE_DATA_W;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0] out_data1, out_data0;
  logic [1:0]   count1, count0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] got1[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(W), .SKID(1), .CLEAR_ON_FLUSH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .count(count1)
  );

  pipe_stage_skid #(.DATA_W(W), .SKID(0), .CLEAR_ON_FLUSH(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .count(count0)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_payload();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive one cycle of stimulus; expected in_ready comes from model occupancy.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic fl, input logic ordy);
    logic rdy1, rdy0;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    #1;
    if (reset_n) begin
      rdy1 = (q1.size() < 2);
      rdy0 = (q0.size() == 0) || ordy;
      chk("in_ready_skid1", W'(in_ready1), W'(rdy1));
      chk("in_ready_skid0", W'(in_ready0), W'(rdy0));
      if (iv && rdy1 && !fl) q1.push_back(d);
      if (iv && rdy0 && !fl) q0.push_back(d);
    end
  endtask

  // Output monitor: pop and compare on every transfer out, then apply flush.
  always begin
    @(negedge clk);
    #2;
    if (reset_n) begin
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_skid1 got %h want nothing", out_data1);
        end else begin
          chk("pop_skid1", out_data1, q1.pop_front());
        end
        got1.push_back(out_data1);
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_skid0 got %h want nothing", out_data0);
        end else begin
          chk("pop_skid0", out_data0, q0.pop_front());
        end
      end
      if (flush) begin
        q1.delete();
        q0.delete();
      end
    end
  end

  // State monitor: occupancy, valid and head payload just after each edge.
  always begin
    @(posedge clk);
    #1;
    if (reset_n) begin
      chk("count_skid1", W'(count1), W'(q1.size()));
      chk("out_valid_skid1", W'(out_valid1), W'(q1.size() != 0));
      if (q1.size() != 0) chk("out_data_skid1", out_data1, q1[0]);
      chk("count_skid0", W'(count0), W'(q0.size()));
      chk("out_valid_skid0", W'(out_valid0), W'(q0.size() != 0));
      if (q0.size() != 0) chk("out_data_skid0", out_data0, q0[0]);
    end
  end

  task automatic drain();
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    #2;
  endtask

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid1), '0);
    chk("rst_count", W'(count1), '0);
    chk("rst_out_data", out_data1, '0);
    chk("rst_out_data0", out_data0, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready1", W'(in_ready1), W'(1));
    chk("rel_in_ready0", W'(in_ready0), W'(1));

    // Streaming 0x1..0x10
    got1.delete();
    for (int i = 1; i <= 16; i++) cycle(1'b1, W'(i), 1'b0, 1'b1);
    drain();
    chk("stream_len", W'(got1.size()), W'(16));
    for (int i = 0; i < 16 && i < got1.size(); i++) chk("stream_seq", got1[i], W'(i + 1));

    // Stall absorbed by skid, then ordered release
    got1.delete();
    cycle(1'b1, W'('hA), 1'b0, 1'b0);
    cycle(1'b1, W'('hB), 1'b0, 1'b0);
    cycle(1'b1, W'('hC), 1'b0, 1'b0);
    chk("stall_in_ready", W'(in_ready1), '0);
    chk("stall_count", W'(count1), W'(2));
    cycle(1'b1, W'('hC), 1'b0, 1'b1);
    cycle(1'b1, W'('hC), 1'b0, 1'b1);
    drain();
    chk("stall_len", W'(got1.size()), W'(3));
    if (got1.size() == 3) begin
      chk("stall_a", got1[0], W'('hA));
      chk("stall_b", got1[1], W'('hB));
      chk("stall_c", got1[2], W'('hC));
    end

    // Flush with main and skid full plus an incoming beat
    got1.delete();
    cycle(1'b1, W'('hA), 1'b0, 1'b0);
    cycle(1'b1, W'('hB), 1'b0, 1'b0);
    cycle(1'b1, W'('hC), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("flush_out_valid", W'(out_valid1), '0);
    chk("flush_count", W'(count1), '0);
    chk("flush_payload", out_data1, '0);
    drain();
    chk("flush_no_emit", W'(got1.size()), '0);

    // Flush in the same cycle as a transfer out
    got1.delete();
    cycle(1'b1, W'('h5), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("fdrain_count", W'(count1), '0);
    chk("fdrain_len", W'(got1.size()), W'(1));
    if (got1.size() == 1) chk("fdrain_val", got1[0], W'('h5));

    // Alternating out_ready with continuous input
    for (int i = 0; i < 12; i++) cycle(1'b1, rnd_payload(), 1'b0, (i % 2) == 0);
    drain();

    // Asynchronous reset mid-cycle with main and skid full
    cycle(1'b1, rnd_payload(), 1'b0, 1'b0);
    cycle(1'b1, rnd_payload(), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    chk("mid_rst_out_valid", W'(out_valid1), '0);
    chk("mid_rst_count", W'(count1), '0);
    chk("mid_rst_out_data", out_data1, '0);
    chk("mid_rst_count0", W'(count0), '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", W'(in_ready1), W'(1));

    // Random traffic with stalls and rare flushes
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 3) != 0), rnd_payload(), 1'($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 2) != 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
